// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode constants, instruction field
// positions and a field-split helper.
package decode_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  // Field bit positions within a 16-bit instruction word.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RS_MSB     = 8;
  localparam int RS_LSB     = 6;
  localparam int RT_MSB     = 5;
  localparam int RT_LSB     = 3;
  localparam int FUNCT_MSB  = 2;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM6_MSB   = 5;
  localparam int IMM12_MSB  = 11;

  // Opcode 0 is the R-type ALU group; the all-zero word is the NOP bubble.
  typedef enum logic [3:0] {
    OP_ALU  = 4'h0,
    OP_ADDI = 4'h1,
    OP_ANDI = 4'h2,
    OP_ORI  = 4'h3,
    OP_BEQ  = 4'h4,
    OP_BNE  = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_J    = 4'h8
  } opcode_e;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [2:0]        funct;
    logic [5:0]        imm6;
    logic [11:0]       imm12;
  } fields_t;

  function automatic fields_t split_fields(input logic [INSTR_W-1:0] instr);
    fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
    f.imm6   = instr[IMM6_MSB:0];
    f.imm12  = instr[IMM12_MSB:0];
    return f;
  endfunction

endpackage

// File: rtl/register_file.sv
// NREG x WIDTH register file: two combinational read ports, one write port,
// r0 hard-wired to zero, and same-cycle write-through to the read ports.
module register_file
  import decode_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_live;

  // A write that reset is about to override must not be bypassed either.
  assign wr_live = we && !reset && (wa != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0)                rd1 = '0;
    else if (wr_live && wa == ra1) rd1 = wd;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0)                rd2 = '0;
    else if (wr_live && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: IF/ID register with stall/flush, field decode,
// register file reads and zero-latency branch/jump resolution.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instructionf,
  input  logic [WIDTH-1:0]  pc_plus_2f,
  input  logic              stalld,
  input  logic              forward_ad,
  input  logic              forward_bd,
  input  logic [WIDTH-1:0]  alu_out_m,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic [WIDTH-1:0]  result_w,
  output logic [WIDTH-1:0]  pc_branch_d,
  output logic              pcsrc_d,
  output logic [WIDTH-1:0]  rd1_d,
  output logic [WIDTH-1:0]  rd2_d,
  output logic [WIDTH-1:0]  imm_ext_d,
  output logic [3:0]        opcode_d,
  output logic [REG_AW-1:0] rs_d,
  output logic [REG_AW-1:0] rt_d,
  output logic [REG_AW-1:0] rd_d,
  output logic [2:0]        funct_d
);

  logic [WIDTH-1:0] instr_d;
  logic [WIDTH-1:0] pc_plus_2d;
  fields_t          f;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] rel_target;
  logic [WIDTH-1:0] abs_target;

  // Stall wins over flush: a held branch keeps its slot until the stall lifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d    <= NOP_INSTR;
      pc_plus_2d <= '0;
    end else if (!stalld) begin
      instr_d    <= pcsrc_d ? NOP_INSTR : instructionf;
      pc_plus_2d <= pc_plus_2f;
    end
  end

  assign f         = split_fields(instr_d);
  assign opcode_d  = f.opcode;
  assign rd_d      = f.rd;
  assign rs_d      = f.rs;
  assign rt_d      = f.rt;
  assign funct_d   = f.funct;
  assign imm_ext_d = {{(WIDTH-6){f.imm6[5]}}, f.imm6};

  register_file #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (f.rs),
    .ra2   (f.rt),
    .we    (regwrite_w),
    .wa    (write_reg_w),
    .wd    (result_w),
    .rd1   (rd1_d),
    .rd2   (rd2_d)
  );

  assign src_a      = forward_ad ? alu_out_m : rd1_d;
  assign src_b      = forward_bd ? alu_out_m : rd2_d;
  assign rel_target = pc_plus_2d + (imm_ext_d << 1);
  assign abs_target = {pc_plus_2d[WIDTH-1:WIDTH-3], f.imm12, 1'b0};

  always_comb begin
    pcsrc_d     = 1'b0;
    pc_branch_d = rel_target;
    case (f.opcode)
      OP_BEQ: pcsrc_d = (src_a == src_b);
      OP_BNE: pcsrc_d = (src_a != src_b);
      OP_J: begin
        pcsrc_d     = 1'b1;
        pc_branch_d = abs_target;
      end
      default: pcsrc_d = 1'b0;
    endcase
  end

endmodule
